scroll_sched: RTL
=================

// Module: scroll_sched
// PURPOSE
//  Scroll scheduler for the OLED virtual canvas. Advances a horizontal column offset at a fixed
//  step rate, dwells at each screen-aligned position, wraps at canvas end, and accepts page jumps.
//  Sits between pixel_ctrl (col/row scan) and full_disp (col_all/row_all lookup).
//  Offset commits only at a frame boundary so a displayed frame never tears.
// PARAMETERS
//  TICK_CYCLES  400_000  clk cycles per scroll step (>=2)
//  CANVAS_W     1152     canvas width in columns; must be a multiple of SCREEN_W, <= 2048
//  SCREEN_W     128      visible width in columns (power of 2)
//  DWELL_STEPS  250      step ticks held at each screen-aligned offset (0 = no dwell)
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous reset, active-high
//  en         in   1   1 = run scheduler, 0 = hold (IDLE)
//  dir        in   1   0 = offset increments, 1 = offset decrements
//  jump_req   in   1   single-cycle pulse: jump to screen jump_page
//  jump_page  in   4   target screen index (valid 0..CANVAS_W/SCREEN_W-1)
//  disp_col   in   7   current scan column from pixel_ctrl
//  disp_row   in   3   current scan page from pixel_ctrl
//  col_all    out  11  canvas column = (offset+disp_col) mod CANVAS_W, combinational
//  row_all    out  3   = disp_row, combinational
//  offset     out  11  committed offset, registered
//  page_idx   out  4   floor(offset/SCREEN_W), registered with offset
//  scrolling  out  1   1 while FSM in SCROLL
// BEHAVIOUR
//  - Reset: state=IDLE, tgt=0, offset=0, page_idx=0, prescaler=0, dwell_cnt=0, scrolling=0.
//  - Prescaler: counts 0..TICK_CYCLES-1 while en=1; step_tick=1 on the cycle it reads TICK_CYCLES-1,
//    then wraps to 0. Held at 0 while en=0; cleared on accepted jump.
//  - FSM IDLE: en=1 -> DWELL (dwell_cnt=0). Any state with en=0 -> IDLE next cycle; tgt held.
//  - DWELL: DWELL_STEPS=0 -> SCROLL next cycle. Else each step_tick dwell_cnt++; the tick with
//    dwell_cnt==DWELL_STEPS-1 -> SCROLL, dwell_cnt=0.
//  - SCROLL: each step_tick tgt=tgt+1 (dir=0) or tgt-1 (dir=1), modulo CANVAS_W
//    (CANVAS_W-1 -> 0 forward; 0 -> CANVAS_W-1 backward). If new tgt % SCREEN_W == 0 -> DWELL.
//  - Jump: jump_req with jump_page < CANVAS_W/SCREEN_W -> tgt=jump_page*SCREEN_W, prescaler=0,
//    dwell_cnt=0; state -> DWELL (stays IDLE if en=0). Out-of-range page: request ignored.
//    Jump has priority over step_tick in the same cycle.
//  - Frame boundary fb: (disp_col,disp_row)==(0,0) this cycle and registered previous pair !=(0,0).
//    Previous pair resets to (127,7), so first (0,0) after reset is a boundary.
//  - Commit: on fb cycle offset<=tgt and page_idx<=tgt/SCREEN_W; visible next cycle. No other
//    offset updates. tgt change and fb same cycle: the new tgt value commits on the next fb.
//  - col_all: 12-bit sum s=offset+disp_col; col_all = (s>=CANVAS_W) ? s-CANVAS_W : s.
//  - dir change mid-SCROLL takes effect at the next step_tick; no state change.
// TESTING (TICK_CYCLES=4, CANVAS_W=384, SCREEN_W=128, DWELL_STEPS=2, fb forced every 8 cycles)
//  1 rst, en=1 -> 2 ticks (8 clk) in DWELL, then SCROLL; tgt 1,2,3.. per tick; offset follows
//    only on fb cycles; scrolling=1 from DWELL exit until tgt==128, then 0 for 2 ticks.
//  2 Forward wrap: tgt=383, tick -> tgt=0, DWELL entered; after fb offset=0, page_idx=0.
//  3 dir=1 from tgt=0 in SCROLL -> tgt=383; with offset=383, disp_col=5 -> col_all=4.
//  4 jump_req page=2 coincident with step_tick -> tgt=256, DWELL, prescaler=0; page=3 -> ignored.
//  5 en=0 mid-SCROLL at tgt=50 -> IDLE next cycle, tgt stays 50 over 100 cycles, scrolling=0.
//  6 rst asserted mid-SCROLL with offset=200 -> next cycle offset=0, IDLE, prescaler=0.

Source files
------------

// File: rtl/scroll_if.sv
// Scroll scheduler bus: run controls and scan position in, canvas lookup and offset state out.
interface scroll_if;
  logic        en;
  logic        dir;
  logic        jump_req;
  logic [3:0]  jump_page;
  logic [6:0]  disp_col;
  logic [2:0]  disp_row;
  logic [10:0] col_all;
  logic [2:0]  row_all;
  logic [10:0] offset;
  logic [3:0]  page_idx;
  logic        scrolling;

  modport master (
    output en, dir, jump_req, jump_page, disp_col, disp_row,
    input  col_all, row_all, offset, page_idx, scrolling
  );

  modport slave (
    input  en, dir, jump_req, jump_page, disp_col, disp_row,
    output col_all, row_all, offset, page_idx, scrolling
  );
endinterface

// File: rtl/scroll_sched.sv
// Horizontal scroll scheduler for the OLED virtual canvas: stepped offset with dwell at screen
// boundaries, wrap, page jumps, and tear-free commit of the offset at frame boundaries.
module scroll_sched #(
  parameter int TICK_CYCLES = 400_000,
  parameter int CANVAS_W    = 1152,
  parameter int SCREEN_W    = 128,
  parameter int DWELL_STEPS = 250
) (
  input  logic     clk,
  input  logic     rst,
  scroll_if.slave  bus
);

  localparam int OW      = 11;
  localparam int SUM_W   = OW + 1;
  localparam int PW      = $clog2(TICK_CYCLES);
  localparam int SW_BITS = $clog2(SCREEN_W);
  localparam int PAGES   = CANVAS_W / SCREEN_W;
  localparam int DW      = (DWELL_STEPS > 2) ? $clog2(DWELL_STEPS) : 1;

  localparam logic [OW-1:0] CANVAS_LAST = OW'(CANVAS_W - 1);
  localparam logic [PW-1:0] TICK_LAST   = PW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_LAST  = DW'(DWELL_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    SCROLL
  } state_t;

  state_t        state, state_nxt;
  logic [OW-1:0] tgt, tgt_nxt, tgt_step, jump_tgt;
  logic [DW-1:0] dwell_cnt, dwell_nxt;
  logic [PW-1:0] presc;
  logic [OW-1:0] offset_q;
  logic [3:0]    page_q;
  logic [6:0]    prev_col;
  logic [2:0]    prev_row;
  logic          step_tick, jump_ok, fb;
  logic [SUM_W-1:0] col_sum;

  assign step_tick = bus.en && (presc == TICK_LAST);
  assign jump_ok   = bus.jump_req && ({1'b0, bus.jump_page} < 5'(PAGES));
  assign jump_tgt  = OW'(bus.jump_page) << SW_BITS;
  assign fb        = (bus.disp_col == '0) && (bus.disp_row == '0) &&
                     !((prev_col == '0) && (prev_row == '0));

  // Wrap at both canvas ends so the canvas behaves as a ring.
  always_comb begin
    tgt_step = tgt + OW'(1);
    if (bus.dir) begin
      tgt_step = (tgt == '0) ? CANVAS_LAST : tgt - OW'(1);
    end else if (tgt == CANVAS_LAST) begin
      tgt_step = '0;
    end
  end

  // NOTE: every signal gets its default before any branch, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    dwell_nxt = dwell_cnt;
    if (jump_ok) begin
      tgt_nxt   = jump_tgt;
      dwell_nxt = '0;
      state_nxt = bus.en ? DWELL : IDLE;
    end else if (!bus.en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = DWELL;
          dwell_nxt = '0;
        end
        DWELL: begin
          if (DWELL_STEPS == 0) begin
            state_nxt = SCROLL;
          end else if (step_tick) begin
            if (dwell_cnt == DWELL_LAST) begin
              state_nxt = SCROLL;
              dwell_nxt = '0;
            end else begin
              dwell_nxt = dwell_cnt + DW'(1);
            end
          end
        end
        SCROLL: begin
          if (step_tick) begin
            tgt_nxt = tgt_step;
            if (tgt_step[SW_BITS-1:0] == '0) begin
              state_nxt = DWELL;
              dwell_nxt = '0;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments and a synchronous reset sampled on clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tgt       <= '0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_nxt;
      tgt       <= tgt_nxt;
      dwell_cnt <= dwell_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.en || jump_ok || step_tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Previous scan pair resets off-origin so the first (0,0) after reset is a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_col <= 7'd127;
      prev_row <= 3'd7;
    end else begin
      prev_col <= bus.disp_col;
      prev_row <= bus.disp_row;
    end
  end

  // The pre-update tgt commits, so a tgt change on a boundary cycle waits for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q <= '0;
      page_q   <= '0;
    end else if (fb) begin
      offset_q <= tgt;
      page_q   <= 4'(tgt >> SW_BITS);
    end
  end

  assign col_sum       = {1'b0, offset_q} + SUM_W'(bus.disp_col);
  assign bus.col_all   = (col_sum >= SUM_W'(CANVAS_W)) ? OW'(col_sum - SUM_W'(CANVAS_W))
                                                       : col_sum[OW-1:0];
  assign bus.row_all   = bus.disp_row;
  assign bus.offset    = offset_q;
  assign bus.page_idx  = page_q;
  assign bus.scrolling = (state == SCROLL);

endmodule
